// File: rtl/carry_chain_sequencer_if.sv
// Operand/result handshake and carry-chain slice bus for carry_chain_sequencer.
// op_sub exists only when CARRY_CHAIN_SUB_EN is defined.
interface carry_chain_sequencer_if #(
    parameter int INPUTS = 4,
    parameter int WORDS  = 4
);
    localparam int W = INPUTS * WORDS;

    logic              op_valid;
    logic              op_ready;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic              op_cin;
`ifdef CARRY_CHAIN_SUB_EN
    logic              op_sub;
`endif
    logic [INPUTS-1:0] chain_p;
    logic [INPUTS-1:0] chain_g;
    logic              chain_ci;
    logic [INPUTS-1:0] chain_s;
    logic              chain_co;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_co;

    modport slave (
        input  op_valid, op_a, op_b, op_cin,
`ifdef CARRY_CHAIN_SUB_EN
        input  op_sub,
`endif
        input  chain_s, chain_co, res_ready,
        output op_ready, chain_p, chain_g, chain_ci, res_valid, res_sum, res_co
    );

    modport master (
        output op_valid, op_a, op_b, op_cin,
`ifdef CARRY_CHAIN_SUB_EN
        output op_sub,
`endif
        output chain_s, chain_co, res_ready,
        input  op_ready, chain_p, chain_g, chain_ci, res_valid, res_sum, res_co
    );
endinterface

// File: rtl/carry_chain_sequencer.sv
// Sequences a wide add through a narrow external carry-chain slice, LSB slice first.
// Optional macro CARRY_CHAIN_SUB_EN adds op_sub (A - B - borrow).
module carry_chain_sequencer #(
    parameter int INPUTS = 4,
    parameter int WORDS  = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    carry_chain_sequencer_if.slave bus
);
    localparam int W  = INPUTS * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, b_q, res_sum_q;
    logic [KW-1:0]     k_q;
    logic              res_co_q;
    logic [INPUTS-1:0] chain_p_q, chain_g_q, p_d, g_d;
    logic              chain_ci_q, ci_d;
    logic [W-1:0]      b_in;
    logic              cin_in;
    logic              last;
    logic [IW-1:0]     cur_base, nxt_base;

    // Subtract folds into the add: B is stored pre-inverted and borrow-in becomes ~cin.
`ifdef CARRY_CHAIN_SUB_EN
    assign b_in   = bus.op_sub ? ~bus.op_b : bus.op_b;
    assign cin_in = bus.op_sub ? ~bus.op_cin : bus.op_cin;
`else
    assign b_in   = bus.op_b;
    assign cin_in = bus.op_cin;
`endif

    assign last     = (k_q == KW'(WORDS - 1));
    assign cur_base = IW'(INPUTS * int'(k_q));
    assign nxt_base = last ? cur_base : IW'(INPUTS * (int'(k_q) + 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Chain drive is computed for the slice of the *next* cycle and registered,
    // so chain_ci_q also serves as the carry register between slices.
    always_comb begin
        state_d = state_q;
        p_d     = '0;
        g_d     = '0;
        ci_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    state_d = RUN;
                    p_d     = bus.op_a[INPUTS-1:0] ^ b_in[INPUTS-1:0];
                    g_d     = bus.op_a[INPUTS-1:0] & b_in[INPUTS-1:0];
                    ci_d    = cin_in;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    p_d  = a_q[nxt_base +: INPUTS] ^ b_q[nxt_base +: INPUTS];
                    g_d  = a_q[nxt_base +: INPUTS] & b_q[nxt_base +: INPUTS];
                    ci_d = bus.chain_co;
                end
            end
            DONE: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            res_sum_q  <= '0;
            res_co_q   <= 1'b0;
            chain_p_q  <= '0;
            chain_g_q  <= '0;
            chain_ci_q <= 1'b0;
        end else begin
            chain_p_q  <= p_d;
            chain_g_q  <= g_d;
            chain_ci_q <= ci_d;
            if (state_q == IDLE && bus.op_valid) begin
                a_q <= bus.op_a;
                b_q <= b_in;
                k_q <= '0;
            end
            if (state_q == RUN) begin
                res_sum_q[cur_base +: INPUTS] <= bus.chain_s;
                if (last) res_co_q <= bus.chain_co;
                else      k_q      <= k_q + KW'(1);
            end
        end
    end

    assign bus.op_ready  = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_sum   = res_sum_q;
    assign bus.res_co    = res_co_q;
    assign bus.chain_p   = chain_p_q;
    assign bus.chain_g   = chain_g_q;
    assign bus.chain_ci  = chain_ci_q;
endmodule

// File: tb/tb_carry_chain_sequencer.sv
// Self-checking bench for carry_chain_sequencer (WORDS=4 and WORDS=1 instances),
// with a behavioural carry-chain slice and an arithmetic reference model.
module tb_carry_chain_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    carry_chain_sequencer_if #(.INPUTS(4), .WORDS(4)) bus4 ();
    carry_chain_sequencer_if #(.INPUTS(4), .WORDS(1)) bus1 ();

    carry_chain_sequencer #(.INPUTS(4), .WORDS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    carry_chain_sequencer #(.INPUTS(4), .WORDS(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // A carry-chain slice adds a+b+ci; with p=a^b, g=a&b that sum is p + 2g + ci.
    logic [4:0] chain_sum4, chain_sum1;
    assign chain_sum4    = 5'(bus4.chain_p) + 5'(bus4.chain_g) * 5'd2 + 5'(bus4.chain_ci);
    assign bus4.chain_s  = chain_sum4[3:0];
    assign bus4.chain_co = chain_sum4[4];
    assign chain_sum1    = 5'(bus1.chain_p) + 5'(bus1.chain_g) * 5'd2 + 5'(bus1.chain_ci);
    assign bus1.chain_s  = chain_sum1[3:0];
    assign bus1.chain_co = chain_sum1[4];

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sl(input logic [15:0] v, input int j);
        logic [15:0] t;
        t = v >> (4 * j);
        return t[3:0];
    endfunction

    // Carry into bit 4j of a+b+c.
    function automatic logic exp_ci(input logic [15:0] a, input logic [15:0] b, input logic c, input int j);
        longint unsigned m, s;
        m = (64'd1 << (4 * j)) - 64'd1;
        s = (64'(a) & m) + (64'(b) & m) + 64'(c);
        return ((s >> (4 * j)) & 64'd1) != 64'd0;
    endfunction

    // Starts and ends on a negedge with the WORDS=4 instance idle.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input int hold);
        logic [15:0] be, esum;
        logic        ce, eco;
        logic [16:0] full;
        int          diff;
        if (sub) begin
            be   = ~b;
            ce   = ~cin;
            diff = int'(a) - int'(b) - int'(cin);
            esum = diff[15:0];
            eco  = (diff >= 0);
        end else begin
            be   = b;
            ce   = cin;
            full = 17'(a) + 17'(b) + 17'(cin);
            esum = full[15:0];
            eco  = full[16];
        end
        chk("idle_op_ready", bus4.op_ready, 1);
        chk("idle_res_valid", bus4.res_valid, 0);
        bus4.op_valid = 1'b1;
        bus4.op_a     = a;
        bus4.op_b     = b;
        bus4.op_cin   = cin;
`ifdef CARRY_CHAIN_SUB_EN
        bus4.op_sub   = sub;
`endif
        @(negedge clk);
        bus4.op_valid = 1'b0;
        bus4.op_a     = 16'($urandom);
        bus4.op_b     = 16'($urandom);
        bus4.op_cin   = 1'($urandom);
        for (int j = 0; j < 4; j++) begin
            chk("run_op_ready", bus4.op_ready, 0);
            chk("run_res_valid", bus4.res_valid, 0);
            chk("chain_ci", bus4.chain_ci, exp_ci(a, be, ce, j));
            chk("chain_p", bus4.chain_p, sl(a ^ be, j));
            chk("chain_g", bus4.chain_g, sl(a & be, j));
            @(negedge clk);
        end
        chk("res_valid", bus4.res_valid, 1);
        chk("res_sum", bus4.res_sum, esum);
        chk("res_co", bus4.res_co, eco);
        chk("done_chain_p", bus4.chain_p, 0);
        for (int h = 0; h < hold; h++) begin
            bus4.op_valid = 1'b1;
            @(negedge clk);
            chk("hold_res_valid", bus4.res_valid, 1);
            chk("hold_res_sum", bus4.res_sum, esum);
            chk("hold_res_co", bus4.res_co, eco);
            chk("hold_op_ready", bus4.op_ready, 0);
        end
        bus4.op_valid  = 1'b0;
        bus4.res_ready = 1'b1;
        @(negedge clk);
        bus4.res_ready = 1'b0;
        chk("release_op_ready", bus4.op_ready, 1);
        chk("release_res_valid", bus4.res_valid, 0);
    endtask

    task automatic do_op1(input logic [3:0] a, input logic [3:0] b, input logic cin);
        logic [4:0] full;
        full = 5'(a) + 5'(b) + 5'(cin);
        chk("w1_idle_op_ready", bus1.op_ready, 1);
        bus1.op_valid = 1'b1;
        bus1.op_a     = a;
        bus1.op_b     = b;
        bus1.op_cin   = cin;
        @(negedge clk);
        bus1.op_valid = 1'b0;
        chk("w1_run_res_valid", bus1.res_valid, 0);
        chk("w1_chain_ci", bus1.chain_ci, cin);
        chk("w1_chain_p", bus1.chain_p, a ^ b);
        chk("w1_chain_g", bus1.chain_g, a & b);
        @(negedge clk);
        chk("w1_res_valid", bus1.res_valid, 1);
        chk("w1_res_sum", bus1.res_sum, full[3:0]);
        chk("w1_res_co", bus1.res_co, full[4]);
        bus1.res_ready = 1'b1;
        @(negedge clk);
        bus1.res_ready = 1'b0;
        chk("w1_release_op_ready", bus1.op_ready, 1);
    endtask

    initial begin
        bus4.op_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.op_cin = 1'b0; bus4.res_ready = 1'b0;
        bus1.op_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.op_cin = 1'b0; bus1.res_ready = 1'b0;
`ifdef CARRY_CHAIN_SUB_EN
        bus4.op_sub = 1'b0;
        bus1.op_sub = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("rst_op_ready", bus4.op_ready, 1);
        chk("rst_res_valid", bus4.res_valid, 0);
        chk("rst_res_sum", bus4.res_sum, 0);
        chk("rst_res_co", bus4.res_co, 0);
        chk("rst_chain", {bus4.chain_p, bus4.chain_g, bus4.chain_ci}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 5);

        // Abort an operation while slice 2 is on the chain.
        bus4.op_valid = 1'b1;
        bus4.op_a     = 16'h1111;
        bus4.op_b     = 16'h2222;
        bus4.op_cin   = 1'b0;
        @(negedge clk);
        bus4.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_chain_p_k2", bus4.chain_p, 4'h3);
        rst_n = 1'b0;
        #1;
        chk("abort_op_ready", bus4.op_ready, 1);
        chk("abort_res_valid", bus4.res_valid, 0);
        chk("abort_res_sum", bus4.res_sum, 0);
        chk("abort_res_co", bus4.res_co, 0);
        chk("abort_chain", {bus4.chain_p, bus4.chain_g, bus4.chain_ci}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

        do_op1(4'hF, 4'h1, 1'b0);
        do_op1(4'($urandom), 4'($urandom), 1'($urandom));

`ifdef CARRY_CHAIN_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1);
`endif

        for (int i = 0; i < 16; i++) begin
            logic s;
`ifdef CARRY_CHAIN_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            do_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), s, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
